game_ctrl: RTL

Frame-rate game sequencer for the 640×480 pixel pipeline. It samples the player buttons and runs the title/play/over state machine once per frame. It also advances the player, shot and target positions and keeps score. Its position and state outputs feed the renderer that sits alongside the raster counters, and it consumes the same `sx`/`sy` scan position.

---
 rtl/game_pkg.sv | 15 +
 rtl/game_ctrl_if.sv | 33 +++
 rtl/btn_sync.sv | 37 +++
 rtl/game_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding and raster geometry for the game sequencer.
package game_pkg;

   typedef enum logic [1:0] {
      TITLE = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2
   } game_state_t;

   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int H_LAST = 639;
   localparam int V_LAST = 479;

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: button and scan-position inputs plus renderer-facing outputs.
// There is no valid/ready handshake: frame_tick is a one-cycle strobe that is
// high only while sx==639 && sy==479, and every other output is a level that
// changes only on the clock edge that ends that strobe cycle.
interface game_ctrl_if;
   logic       btn_up;
   logic       btn_dn;
   logic       btn_fire;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       frame_tick;
   logic [1:0] game_state;
   logic [9:0] player_y;
   logic       shot_active;
   logic [9:0] shot_x;
   logic [9:0] shot_y;
   logic [9:0] target_y;
   logic [7:0] score;

   // master: buttons and raster counters side
   modport master (
      output btn_up, btn_dn, btn_fire, sx, sy,
      input  frame_tick, game_state, player_y, shot_active,
             shot_x, shot_y, target_y, score
   );

   // slave: the game sequencer itself
   modport slave (
      input  btn_up, btn_dn, btn_fire, sx, sy,
      output frame_tick, game_state, player_y, shot_active,
             shot_x, shot_y, target_y, score
   );
endinterface

// File: rtl/btn_sync.sv
// btn_sync: 2-flop synchronizer for one raw button plus a frame-sampled
// rising-edge detector. o_level and o_rise are meaningful on the tick cycle.
module btn_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   input  logic i_tick,
   output logic o_level,
   output logic o_rise
);
   logic r_s1;
   logic r_s2;
   logic r_prev;

   // free-running synchronizer chain for the asynchronous button
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
      end
   end

   // remember the level seen at the previous frame tick
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= 1'b0;
      end else if (i_tick) begin
         r_prev <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_prev;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: title/play/over sequencer with player, shot, target and score
// datapath. Every register moves only on the frame_tick cycle.
module game_ctrl
   import game_pkg::*;
#(
   parameter int PLAYER_X     = 32,
   parameter int PLAYER_W     = 16,
   parameter int PLAYER_H     = 64,
   parameter int PLAYER_SPD   = 4,
   parameter int SHOT_SPD     = 8,
   parameter int TARGET_X     = 600,
   parameter int TARGET_H     = 48,
   parameter int TGT_SPD      = 2,
   parameter int ROUND_FRAMES = 1800,
   parameter int OVER_FRAMES  = 120
) (
   input  logic       clk_pix,
   input  logic       sim_rst,
   game_ctrl_if.slave bus
);
   localparam logic [9:0]         PLAYER_Y0  = 10'((V_RES - PLAYER_H) / 2);
   localparam logic signed [10:0] PLAYER_MAX = 11'(V_RES - PLAYER_H);
   localparam logic signed [10:0] TGT_MAX    = 11'(V_RES - TARGET_H);
   localparam logic [9:0]         SHOT_X0    = 10'(PLAYER_X + PLAYER_W);
   // one counter serves both the round and the OVER hold; 11 bits covers 1800
   localparam logic [10:0]        ROUND_LAST = 11'(ROUND_FRAMES - 1);
   localparam logic [10:0]        OVER_LAST  = 11'(OVER_FRAMES - 1);

   game_state_t r_state, w_state_nxt;
   logic [9:0]  r_player_y, w_player_nxt;
   logic        r_shot_active, w_shot_active_nxt;
   logic [9:0]  r_shot_x, w_shot_x_nxt;
   logic [9:0]  r_shot_y, w_shot_y_nxt;
   logic [9:0]  r_target_y, w_target_nxt;
   logic        r_tgt_up, w_tgt_up_nxt;
   logic [7:0]  r_score, w_score_nxt;
   logic [10:0] r_cnt, w_cnt_nxt;

   logic w_tick, w_up, w_dn, w_fire_pe;
   logic w_up_rise, w_dn_rise, w_fire_lvl, w_unused;
   logic signed [10:0] w_py_up, w_py_dn, w_ty_up, w_ty_dn;
   logic [10:0] w_sx_new;
   logic        w_hit;

   assign w_tick = (bus.sx == 10'(H_LAST)) && (bus.sy == 10'(V_LAST));

   btn_sync u_sync_up   (.i_clk(clk_pix), .i_rst(sim_rst), .i_btn(bus.btn_up),
                         .i_tick(w_tick), .o_level(w_up), .o_rise(w_up_rise));
   btn_sync u_sync_dn   (.i_clk(clk_pix), .i_rst(sim_rst), .i_btn(bus.btn_dn),
                         .i_tick(w_tick), .o_level(w_dn), .o_rise(w_dn_rise));
   btn_sync u_sync_fire (.i_clk(clk_pix), .i_rst(sim_rst), .i_btn(bus.btn_fire),
                         .i_tick(w_tick), .o_level(w_fire_lvl), .o_rise(w_fire_pe));

   // movement uses levels for up/down and only the edge for fire
   assign w_unused = w_up_rise ^ w_dn_rise ^ w_fire_lvl;

   // 11-bit signed candidates so clamping happens before any wrap
   assign w_py_up  = $signed({1'b0, r_player_y}) - $signed(11'(PLAYER_SPD));
   assign w_py_dn  = $signed({1'b0, r_player_y}) + $signed(11'(PLAYER_SPD));
   assign w_ty_up  = $signed({1'b0, r_target_y}) - $signed(11'(TGT_SPD));
   assign w_ty_dn  = $signed({1'b0, r_target_y}) + $signed(11'(TGT_SPD));
   assign w_sx_new = {1'b0, r_shot_x} + 11'(SHOT_SPD);
   // hit test uses the new shot x against the pre-move target row
   assign w_hit    = r_shot_active && (w_sx_new >= 11'(TARGET_X)) &&
                     (r_shot_y >= r_target_y) &&
                     ({1'b0, r_shot_y} < ({1'b0, r_target_y} + 11'(TARGET_H)));

   // state and datapath registers
   always_ff @(posedge clk_pix) begin
      if (sim_rst) begin
         r_state       <= TITLE;
         r_player_y    <= PLAYER_Y0;
         r_shot_active <= 1'b0;
         r_shot_x      <= 10'd0;
         r_shot_y      <= 10'd0;
         r_target_y    <= 10'd0;
         r_tgt_up      <= 1'b0;
         r_score       <= 8'd0;
         r_cnt         <= 11'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_player_y    <= w_player_nxt;
         r_shot_active <= w_shot_active_nxt;
         r_shot_x      <= w_shot_x_nxt;
         r_shot_y      <= w_shot_y_nxt;
         r_target_y    <= w_target_nxt;
         r_tgt_up      <= w_tgt_up_nxt;
         r_score       <= w_score_nxt;
         r_cnt         <= w_cnt_nxt;
      end
   end

   // next-state and datapath: everything holds unless this is the tick cycle
   always_comb begin
      w_state_nxt       = r_state;
      w_player_nxt      = r_player_y;
      w_shot_active_nxt = r_shot_active;
      w_shot_x_nxt      = r_shot_x;
      w_shot_y_nxt      = r_shot_y;
      w_target_nxt      = r_target_y;
      w_tgt_up_nxt      = r_tgt_up;
      w_score_nxt       = r_score;
      w_cnt_nxt         = r_cnt;
      if (w_tick) begin
         unique case (r_state)
            TITLE: begin
               if (w_fire_pe) begin
                  w_state_nxt       = PLAY;
                  w_player_nxt      = PLAYER_Y0;
                  w_target_nxt      = 10'd0;
                  w_tgt_up_nxt      = 1'b0;
                  w_score_nxt       = 8'd0;
                  w_shot_active_nxt = 1'b0;
                  w_cnt_nxt         = 11'd0;
               end
            end
            PLAY: begin
               if (w_up && !w_dn) begin
                  w_player_nxt = (w_py_up < 11'sd0) ? 10'd0 : w_py_up[9:0];
               end else if (w_dn && !w_up) begin
                  w_player_nxt = (w_py_dn > PLAYER_MAX) ? PLAYER_MAX[9:0] : w_py_dn[9:0];
               end
               if (!r_tgt_up) begin
                  if (w_ty_dn >= TGT_MAX) begin
                     w_target_nxt = TGT_MAX[9:0];
                     w_tgt_up_nxt = 1'b1;
                  end else begin
                     w_target_nxt = w_ty_dn[9:0];
                  end
               end else begin
                  if (w_ty_up <= 11'sd0) begin
                     w_target_nxt = 10'd0;
                     w_tgt_up_nxt = 1'b0;
                  end else begin
                     w_target_nxt = w_ty_up[9:0];
                  end
               end
               if (r_shot_active) begin
                  if (w_hit) begin
                     w_shot_active_nxt = 1'b0;
                     w_shot_x_nxt      = w_sx_new[9:0];
                     w_score_nxt       = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                  end else if (w_sx_new > 11'(H_LAST)) begin
                     w_shot_active_nxt = 1'b0;
                  end else begin
                     w_shot_x_nxt = w_sx_new[9:0];
                  end
               end else if (w_fire_pe) begin
                  w_shot_active_nxt = 1'b1;
                  w_shot_x_nxt      = SHOT_X0;
                  w_shot_y_nxt      = r_player_y + 10'(PLAYER_H / 2);
               end
               // last round tick: drop the shot and discard any hit
               if (r_cnt == ROUND_LAST) begin
                  w_state_nxt       = OVER;
                  w_cnt_nxt         = 11'd0;
                  w_shot_active_nxt = 1'b0;
                  w_score_nxt       = r_score;
               end else begin
                  w_cnt_nxt = r_cnt + 11'd1;
               end
            end
            OVER: begin
               if (r_cnt == OVER_LAST) begin
                  w_state_nxt = TITLE;
                  w_cnt_nxt   = 11'd0;
               end else begin
                  w_cnt_nxt = r_cnt + 11'd1;
               end
            end
            default: w_state_nxt = TITLE;
         endcase
      end
   end

   assign bus.frame_tick  = w_tick;
   assign bus.game_state  = r_state;
   assign bus.player_y    = r_player_y;
   assign bus.shot_active = r_shot_active;
   assign bus.shot_x      = r_shot_x;
   assign bus.shot_y      = r_shot_y;
   assign bus.target_y    = r_target_y;
   assign bus.score       = r_score;
endmodule
